// File: rtl/gcd_core.sv
// rtl/gcd_core.sv - subtractive GCD engine driven by an unsigned magnitude comparator
// comp: three-way compare of two unsigned operands; gcd_core: start/calc/done controller.

module comp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             a_gt_b
);
  assign a_eq_b = (in1 == in2);
  assign a_lt_b = (in1 <  in2);
  assign a_gt_b = (in1 >  in2);
endmodule

module gcd_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_in
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] gcd_q;
  logic             done_q;
  logic             zero_q;
  logic             a_eq_b;
  logic             a_lt_b;
  logic             a_gt_b;

  comp #(.WIDTH(WIDTH)) u_comp (
    .in1    (ra_q),
    .in2    (rb_q),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b),
    .a_gt_b (a_gt_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      gcd_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ra_q   <= in_a;
            rb_q   <= in_b;
            zero_q <= 1'b0;
            // A zero operand short-circuits: OR of the inputs is the other operand (or 0).
            if ((in_a == '0) || (in_b == '0)) begin
              gcd_q   <= in_a | in_b;
              zero_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (a_eq_b) begin
            gcd_q   <= ra_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (a_gt_b) begin
            ra_q <= ra_q - rb_q;
          end else if (a_lt_b) begin
            rb_q <= rb_q - ra_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign gcd_out = gcd_q;
  assign zero_in = zero_q;
endmodule

// File: tb/tb_gcd_core.sv
// tb/tb_gcd_core.sv - randomized and directed checks of gcd_core against a Euclid reference
module tb_gcd_core;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       busy;
  logic       done;
  logic [7:0] gcd_out;
  logic       zero_in;

  int n_checks = 0;
  int n_pass   = 0;

  gcd_core #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_a    (in_a),
    .in_b    (in_b),
    .busy    (busy),
    .done    (done),
    .gcd_out (gcd_out),
    .zero_in (zero_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: modulo Euclid; subtraction count is the sum of partial quotients minus one.
  function automatic int ref_gcd(input int a, input int b);
    int x = a, y = b, t;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  function automatic int ref_latency(input int a, input int b);
    int x = a, y = b, t, qsum = 0;
    if (a == 0 || b == 0) return 1;
    while (y != 0) begin
      qsum += x / y;
      t = x % y; x = y; y = t;
    end
    return qsum - 1 + 2;
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic run(input string tag, input int a, input int b, input bit hold, input bit verbose);
    int lat;
    int busy_low;
    int exp_lat;
    exp_lat  = ref_latency(a, b);
    busy_low = 0;
    start = 1'b1;
    in_a  = a[7:0];
    in_b  = b[7:0];
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    in_a = $urandom_range(0, 255);
    in_b = $urandom_range(0, 255);
    lat = 1;
    while (!done && lat < 400) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      lat++;
    end
    if (verbose || lat != exp_lat) check({tag, "_latency"}, lat, exp_lat);
    if (verbose || done != 1'b1) check({tag, "_done"}, done, 1);
    if (verbose || gcd_out != ref_gcd(a, b)) check({tag, "_gcd"}, gcd_out, ref_gcd(a, b));
    if (verbose || zero_in != (a == 0 || b == 0)) check({tag, "_zero_in"}, zero_in, (a == 0 || b == 0));
    if (verbose || busy_low != 0 || busy != 1'b1) check({tag, "_busy_during"}, busy_low + (busy ? 0 : 1), 0);
    @(posedge clk); #1;
    if (verbose || done != 1'b0) check({tag, "_done_single"}, done, 0);
    if (verbose || busy != 1'b0) check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int a, b, done_seen;
    rst = 1'b1; start = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_gcd", gcd_out, 0);
    check("reset_zero_in", zero_in, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort (48,18) mid-run with a 2-cycle reset.
    start = 1'b1; in_a = 8'd48; in_b = 8'd18;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_gcd", gcd_out, 0);
    check("abort_zero_in", zero_in, 0);
    done_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run("basic_48_18", 48, 18, 1'b0, 1'b1);
    check("basic_latency_const", ref_latency(48, 18), 6);
    for (int i = 0; i < 10; i++) begin
      check("hold_gcd_6", gcd_out, 6);
      @(posedge clk); #1;
    end

    run("eq_7_7", 7, 7, 1'b0, 1'b1);
    run("rev_18_48", 18, 48, 1'b0, 1'b1);
    run("zero_0_35", 0, 35, 1'b0, 1'b1);
    run("zero_0_0", 0, 0, 1'b0, 1'b1);
    run("worst_255_1", 255, 1, 1'b0, 1'b1);
    run("worst_1_255", 1, 255, 1'b0, 1'b1);

    // Held start: ignored while busy, re-accepted in the first IDLE cycle.
    run("held_100_75_a", 100, 75, 1'b1, 1'b1);
    run("held_100_75_b", 100, 75, 1'b1, 1'b1);
    start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(1, 255);
      b = $urandom_range(1, 255);
      run("rand", a, b, 1'b0, (i % 100) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
